// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit. It borrows the core ALU adder and does one add per cycle.
// state  | meaning
// IDLE   | ready for a new operation
// NEG_A  | replace rs1 with its magnitude
// NEG_B  | replace rs2 with its magnitude
// ITER   | 32 shift-add / restoring-divide steps
// NEG_LO | negate the low word (quotient, remainder or product low)
// NEG_HI | negate the product high word with the borrow from NEG_LO
// DONE   | hold the result until the consumer takes it
module ysyx_24080006_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            mdu_enable_o,
    output logic [XLEN:0]   add_a_o,
    output logic [XLEN:0]   add_b_o,
    input  logic [XLEN+1:0] add_res_i
);

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   lo, hi, mcand;
    logic [CNT_W-1:0]  cnt;
    logic              neg_b_q, neg_r_q, neg_c;

    logic              accept, in_div, in_neg_a, in_neg_b, in_neg_r, in_div_zero;
    logic              is_div, is_rem, is_mulhx;
    logic [XLEN:0]     rp;
    logic [XLEN-1:0]   sum;
    logic              carry, success;
    logic              unused_add_lsb;

    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign in_div      = op_i[2];
    assign in_neg_a    = a_i[XLEN-1] & (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4 || op_i == 3'd6);
    assign in_neg_b    = b_i[XLEN-1] & (op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6);
    assign in_neg_r    = (op_i == 3'd1 || op_i == 3'd4) ? (in_neg_a ^ in_neg_b) :
                         (op_i == 3'd2 || op_i == 3'd6) ? in_neg_a : 1'b0;
    assign in_div_zero = in_div & (b_i == '0);

    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    assign is_mulhx = (op_q == 3'd1) || (op_q == 3'd2);

    // Partial remainder shifted left by one with the next dividend bit
    assign rp             = {hi, lo[XLEN-1]};
    assign sum            = add_res_i[XLEN:1];
    assign carry          = add_res_i[XLEN+1];
    assign success        = rp[XLEN] | carry;
    assign unused_add_lsb = add_res_i[0];

    always_comb begin
        add_a_o = '0;
        add_b_o = '0;
        case (state)
            NEG_A: begin
                add_a_o = {{XLEN{1'b0}}, 1'b1};
                add_b_o = {~lo, 1'b1};
            end
            NEG_B: begin
                add_a_o = {{XLEN{1'b0}}, 1'b1};
                add_b_o = {~mcand, 1'b1};
            end
            ITER: begin
                if (is_div) begin
                    add_a_o = {rp[XLEN-1:0], 1'b1};
                    add_b_o = {~mcand, 1'b1};
                end else begin
                    add_a_o = {hi, 1'b0};
                    add_b_o = {(lo[0] ? mcand : {XLEN{1'b0}}), 1'b0};
                end
            end
            NEG_LO: begin
                add_a_o = {{XLEN{1'b0}}, 1'b1};
                add_b_o = {~(is_rem ? hi : lo), 1'b1};
            end
            NEG_HI: begin
                add_a_o = {{XLEN{1'b0}}, neg_c};
                add_b_o = {~hi, neg_c};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_div_zero)   state_nxt = DONE;
                        else if (in_neg_a) state_nxt = NEG_A;
                        else if (in_neg_b) state_nxt = NEG_B;
                        else               state_nxt = ITER;
                    end
                end
                NEG_A:  state_nxt = neg_b_q ? NEG_B : ITER;
                NEG_B:  state_nxt = ITER;
                ITER:   if (cnt == CNT_W'(XLEN-1)) state_nxt = neg_r_q ? NEG_LO : DONE;
                NEG_LO: state_nxt = is_mulhx ? NEG_HI : DONE;
                NEG_HI: state_nxt = DONE;
                DONE:   if (out_ready_i) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            lo      <= '0;
            hi      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            neg_b_q <= 1'b0;
            neg_r_q <= 1'b0;
            neg_c   <= 1'b0;
        end else if (!flush_i) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        mcand   <= b_i;
                        cnt     <= '0;
                        neg_b_q <= in_neg_b;
                        neg_r_q <= in_neg_r;
                        // Divide by zero: quotient all ones, remainder is the dividend
                        if (in_div_zero) begin
                            lo <= '1;
                            hi <= a_i;
                        end else begin
                            lo <= a_i;
                            hi <= '0;
                        end
                    end
                end
                NEG_A: lo    <= sum;
                NEG_B: mcand <= sum;
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        hi <= success ? sum : rp[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], success};
                    end else begin
                        hi <= {carry, sum[XLEN-1:1]};
                        lo <= {sum[0], lo[XLEN-1:1]};
                    end
                end
                NEG_LO: begin
                    neg_c <= (lo == '0);
                    if (is_rem) hi <= sum;
                    else        lo <= sum;
                end
                NEG_HI: hi <= sum;
                default: ;
            endcase
        end
    end

    assign in_ready_o   = (state == IDLE);
    assign out_valid_o  = (state == DONE);
    assign mdu_enable_o = (state == NEG_A) || (state == NEG_B) || (state == ITER) ||
                          (state == NEG_LO) || (state == NEG_HI);

    always_comb begin
        result_o = '0;
        if (state == DONE) begin
            if (op_q == 3'd0)  result_o = lo;
            else if (!is_div)  result_o = hi;
            else if (is_rem)   result_o = hi;
            else               result_o = lo;
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Scoreboard bench for the MDU: stimulus pushes expected results, a monitor checks each handshake.
module tb_ysyx_24080006_mdu;

    logic        clock = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, mdu_enable;
    logic [31:0] result;
    logic [32:0] add_a, add_b;
    logic [33:0] add_res;

    assign add_res = {1'b0, add_a} + {1'b0, add_b};

    ysyx_24080006_mdu dut (
        .clock(clock), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op), .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .mdu_enable_o(mdu_enable), .add_a_o(add_a), .add_b_o(add_b), .add_res_i(add_res)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          en;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: tracks accept cycle, adder ownership cycles and first valid cycle
    initial begin
        int   acc   = 0;
        int   en    = 0;
        int   first = -1;
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (in_valid && in_ready && !flush && rst_n) begin
                acc = cyc; en = 0; first = -1;
            end
            if (mdu_enable) en++;
            if (out_valid && first < 0) first = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got %h expected no output", result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"}, result, e.res);
                    check({e.name, " latency"}, 32'(first - acc), 32'(e.lat));
                    check({e.name, " enable_cycles"}, 32'(en), 32'(e.en));
                end
                first = -1;
            end
        end
    end

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] r, input int lat,
                         input int en, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clock);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL %s in_ready_timeout: got 0 expected 1", nm);
                return;
            end
            @(negedge clock);
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        if (push) begin
            e.res = r; e.lat = lat; e.en = en; e.name = nm;
            sb.push_back(e);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        #2;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset mdu_enable", {31'b0, mdu_enable}, 32'd0);
        check("reset add_a", add_a[31:0], 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        do_op("mul_7x6",       3'd0, 32'd7,        32'd6,        32'd42,       33, 32, 1);
        do_op("mulhu_ffxff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, 1);
        do_op("mulh_ffxff",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35, 34, 1);
        do_op("mulh_m3x5",     3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 36, 35, 1);
        do_op("mulh_carry",    3'd1, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 36, 35, 1);
        do_op("mulhsu_m1",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 36, 35, 1);
        do_op("div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 34, 1);
        do_op("rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 34, 1);
        do_op("div_7_m2",      3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35, 34, 1);
        do_op("div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 34, 1);
        do_op("rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 36, 35, 1);
        do_op("divu_by0",      3'd5, 32'd123,      32'd0,        32'hFFFFFFFF, 1,  0,  1);
        do_op("remu_by0",      3'd7, 32'd123,      32'd0,        32'd123,      1,  0,  1);
        do_op("divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       33, 32, 1);
        do_op("remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        33, 32, 1);

        // Back-pressure: result must hold while the consumer stalls
        do_op("mul_stall",     3'd0, 32'd3,        32'd4,        32'd12,       33, 32, 1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("stall out_valid seen", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall result", result, 32'd12);
            check("stall in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        check("release in_ready", {31'b0, in_ready}, 32'd1);
        check("release out_valid", {31'b0, out_valid}, 32'd0);
        do_op("after_stall",   3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 32, 1);

        // Flush during ITER step 10 of a MULH
        do_op("mulh_flush",    3'd1, 32'd5,        32'd3,        32'd0,        0,  0,  0);
        repeat (10) @(negedge clock);
        check("flush pre mdu_enable", {31'b0, mdu_enable}, 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush mdu_enable", {31'b0, mdu_enable}, 32'd0);

        // Flush together with a request suppresses the accept
        @(negedge clock);
        op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush_accept in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_accept mdu_enable", {31'b0, mdu_enable}, 32'd0);

        do_op("mulhu_small",   3'd3, 32'h80000000, 32'd4,        32'd2,        33, 32, 1);

        // Asynchronous reset in the middle of a DIV
        do_op("div_reset",     3'd4, 32'hFFFFFF00, 32'd3,        32'd0,        0,  0,  0);
        repeat (5) @(negedge clock);
        check("prereset mdu_enable", {31'b0, mdu_enable}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async in_ready", {31'b0, in_ready}, 32'd1);
        check("async out_valid", {31'b0, out_valid}, 32'd0);
        check("async mdu_enable", {31'b0, mdu_enable}, 32'd0);
        check("async result", result, 32'd0);
        check("async add_b", add_b[31:0], 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        do_op("rem_post_rst",  3'd6, 32'd17,       32'd5,        32'd2,        33, 32, 1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
